// File: rtl/led_pkg.sv
// Shared LED definitions: default sizes, MAX helper, saturating subtract and the
// gamma curve used when LED_TRAIL_GAMMA_EN is defined.
package led_pkg;

  localparam int LED_N  = 8;
  localparam int LED_BW = 4;

  function automatic int max_from_bw(input int bw);
    return (1 << bw) - 1;
  endfunction

  function automatic int sat_sub(input int a, input int d);
    return (a > d) ? a - d : 0;
  endfunction

  // Perceptual curve: (b*b + MAX) >> BW keeps f(0)=0 and f(MAX)=MAX.
  function automatic int gamma(input int b, input int bw);
    return (b * b + max_from_bw(bw)) >> bw;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: duty latch updated on the PWM wrap, then a registered compare
// against the shared counter. Define LED_TRAIL_GAMMA_EN to apply the gamma curve.
module pwm_channel
  import led_pkg::*;
#(
  parameter int BW = LED_BW
) (
  input  logic          clk,
  input  logic          rstna,
  input  logic [BW-1:0] bright,
  input  logic [BW-1:0] pwm_cnt,
  input  logic          pwm_wrap,
  output logic          led
);

  logic [BW-1:0] duty;
  logic [BW-1:0] duty_next;

  // NOTE: duty_next is assigned on every path through this block, so no latch is inferred.
  always_comb begin
`ifdef LED_TRAIL_GAMMA_EN
    duty_next = BW'(gamma(int'(bright), BW));
`else
    duty_next = bright;
`endif
  end

  // Duty only moves at the period boundary so a period never mixes two levels.
  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      duty <= '0;
      led  <= 1'b0;
    end else begin
      if (pwm_wrap) duty <= duty_next;
      led <= (duty > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-trail LED driver: one-hot position to per-LED fading brightness, rendered
// through a shared PWM counter. Define LED_TRAIL_GAMMA_EN for gamma-corrected duty.
module led_trail_pwm
  import led_pkg::*;
#(
  parameter int N     = LED_N,
  parameter int BW    = LED_BW,
  parameter int DECAY = 3
) (
  input  logic         clk,
  input  logic         rstna,
  input  logic         step,
  input  logic [N-1:0] pos,
  input  logic         clr_err,
  output logic [N-1:0] led,
  output logic         pwm_wrap,
  output logic         pos_err
);

  localparam int MAX = max_from_bw(BW);

  logic [BW-1:0] pwm_cnt;
  logic          wrap;
  logic [BW-1:0] bright [N];

  // Period is MAX cycles: the counter never reaches MAX itself.
  assign wrap     = (pwm_cnt == BW'(MAX - 1));
  assign pwm_wrap = wrap;

  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna)    pwm_cnt <= '0;
    else if (wrap) pwm_cnt <= '0;
    else           pwm_cnt <= pwm_cnt + 1'b1;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values in parallel.
  // NOTE: the brightness array is plain flops, not RAM, so it is reset with the rest of the state.
  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      for (int i = 0; i < N; i++) bright[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pos[i])    bright[i] <= BW'(MAX);
        else if (step) bright[i] <= BW'(sat_sub(int'(bright[i]), DECAY));
      end
    end
  end

  // Set has priority over clear so a bad sample is never lost.
  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna)                   pos_err <= 1'b0;
    else if ($countones(pos) != 1) pos_err <= 1'b1;
    else if (clr_err)             pos_err <= 1'b0;
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    pwm_channel #(.BW(BW)) u_ch (
      .clk     (clk),
      .rstna   (rstna),
      .bright  (bright[g]),
      .pwm_cnt (pwm_cnt),
      .pwm_wrap(wrap),
      .led     (led[g])
    );
  end

endmodule

// File: doc/led_trail_pwm.md
Name: led_trail_pwm

Overview:
- Downstream consumer of the bouncing one-hot position register.
- Turns the one-hot position vector into a "comet trail" LED pattern:
  - the active LED is driven at full brightness;
  - LEDs the dot has left fade out step by step;
  - every LED is rendered by a shared PWM counter.
- Sits between the position shifter and the board LED pins.
- Also flags malformed (not one-hot) position vectors.

Parameters:
- N, 8: number of LEDs; width of pos and led.
- BW, 4: brightness/duty width in bits. MAX = 2^BW-1.
- DECAY, 3: brightness subtracted from each non-active LED per step. Range 1..MAX.

Ports:
- clk  in  1  system clock
- rstna  in  1  reset, asynchronous, active-low
- step  in  1  one-cycle strobe; same signal that enables the upstream shifter
- pos  in  N  one-hot position vector (the shifter's Q)
- clr_err  in  1  synchronous clear of pos_err
- led  out  N  PWM-modulated LED drive, active-high
- pwm_wrap  out  1  one-cycle pulse on the last count of each PWM period
- pos_err  out  1  sticky flag: pos was not one-hot

Behaviour:
- Reset (async, rstna=0):
  - bright[i]=0, duty[i]=0, pwm_cnt=0;
  - led=0, pwm_wrap=0, pos_err=0.
  - Reset mid-period abandons the period; the block restarts from cnt=0 on release.
- Brightness update, per LED i, every clk:
  - if pos[i]=1, bright[i] <= MAX (regardless of step);
  - else if step=1, bright[i] <= max(bright[i]-DECAY, 0), saturating at 0 with no wrap;
  - else hold.
- The LED just vacated stays at MAX until the first step after pos leaves it.
  - With DECAY=3, BW=4 it takes 5 steps to reach 0: 15,12,9,6,3,0.
- PWM counter:
  - pwm_cnt counts 0..MAX-1, i.e. period = MAX clk cycles (15 for BW=4), then wraps to 0.
  - pwm_wrap=1 during the cycle where pwm_cnt=MAX-1.
- Duty latch:
  - on the pwm_wrap cycle, duty[i] <= f(bright[i]) for all i (f below);
  - otherwise duty holds, so no mid-period glitches.
- Output: led[i] registered, led[i] <= (duty[i] > pwm_cnt).
  - duty=MAX gives constant on; duty=0 gives constant off; duty=k gives k cycles high per period.
- Latency:
  - pos change to bright: 1 clk;
  - bright to duty: until the next wrap (worst case MAX clk);
  - duty to led: 1 clk.
- pos_err:
  - set (registered, 1 clk after the offending sample) when popcount(pos) != 1, including all-zero;
  - cleared by clr_err;
  - if set and clear occur in the same cycle, set wins.
- Multiple bits set in pos: every set bit is forced to MAX; no other special handling.
- step and pos do not need any particular alignment; the block samples pos every cycle.

Optional Feature:
- Macro: LED_TRAIL_GAMMA_EN.
- Defined: f(b) = (b*b + MAX) >> BW, a 2*BW-bit intermediate. This is monotonic with f(0)=0 and f(MAX)=MAX.
  - For BW=4: 15->15, 12->9, 9->6, 6->3, 3->1, 0->0.
- Undefined: f(b) = b, identity, and no multiplier is synthesised.

Decomposition:
- Shared package led_pkg holds:
  - localparams for default N and BW;
  - a MAX-from-BW helper function;
  - a saturating-subtract function;
  - the gamma function, so the shifter testbench and this block share definitions.
- One natural sub-module: pwm_channel, instantiated N times.
  - Contains the duty latch and the comparator register.
  - Takes pwm_cnt and pwm_wrap from a single shared counter in the top.

Test Plan:
- Reset release with pos=8'b1000_0000, no step, run 30 clk -> led[7] constantly 1 after the first wrap + 1 clk; led[6:0]=0; pwm_wrap pulses every 15 clk; pos_err=0.
- pos steps 8'h80->8'h40 with one step strobe, then 5 more steps at pos=8'h40 -> bright[7] sequence 15,12,9,6,3,0 (first decrement on the first step after pos leaves bit 7). led[7] high 12 of 15 cycles in the period after the first decrement. led[6] stays fully on.
- Saturation: DECAY=7, bright=3, step -> bright=0 (not 12); another step -> stays 0.
- pos=8'h00 for 1 clk, then 8'h81 for 1 clk -> pos_err=1 one clk after the first; stays 1; clr_err pulse coincident with a further bad sample keeps pos_err=1; clr_err with pos=8'h10 -> 0.
- rstna pulsed low mid-period while led[3] is high -> led, pwm_wrap, pos_err drop to 0 asynchronously; after release pwm_cnt restarts at 0 and the next wrap occurs 15 clk later.
- LED_TRAIL_GAMMA_EN defined, bright=12 latched -> led high 9 of 15 cycles. Undefined -> 12 of 15.
